// File: rtl/service_reply_tx.sv
// service_reply_tx: serializes a service-protocol reply (4 header words plus
// payload) from the reply buffer into a 16-bit valid/ready word stream.
module service_reply_tx #(
  parameter int unsigned BUF_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        hdr_addr,
  input  logic [15:0]       hdr_size,
  input  logic [7:0]        hdr_cmd,
  input  logic [15:0]       hdr_num,
  output logic [BUF_AW-1:0] rd_addr,
  output logic              rd_en,
  input  logic [15:0]       rd_data,
  output logic [15:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned IW       = BUF_AW + 1;
  localparam int unsigned MAX_SIZE = 32'(1) << BUF_AW;

  typedef enum logic [2:0] {IDLE, SUM, HDR, DATA, FIN} state_t;

  state_t            state_q, state_nxt;
  logic [IW-1:0]     idx_q, idx_nxt;
  logic [15:0]       acc_q, acc_nxt;
  logic [7:0]        addr_q, addr_nxt;
  logic [15:0]       size_q, size_nxt;
  logic [7:0]        cmd_q, cmd_nxt;
  logic [15:0]       num_q, num_nxt;
  logic [1:0]        hcnt_q, hcnt_nxt;
  logic              rd_pend_q, rd_pend_nxt;
  logic              byp_q, byp_nxt;
  logic [15:0]       data_q, data_nxt;
  logic [BUF_AW-1:0] rd_addr_nxt;
  logic              rd_en_nxt, out_valid_nxt, busy_nxt, done_nxt, err_nxt;

  // Unknown command codes are replaced by 0xFF at latch time.
  function automatic logic [7:0] cmd_decode(input logic [7:0] c);
    case (c)
      8'hA0, 8'hA2, 8'hB0, 8'hB2: cmd_decode = c;
      default:                    cmd_decode = 8'hFF;
    endcase
  endfunction

  // The first cycle of a payload word forwards rd_data directly (it arrives one
  // cycle after rd_en); from then on the captured copy keeps the word stable.
  assign out_data = byp_q ? rd_data : data_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      cmd_q     <= '0;
      num_q     <= '0;
      hcnt_q    <= '0;
      rd_pend_q <= 1'b0;
      byp_q     <= 1'b0;
      data_q    <= '0;
      rd_addr   <= '0;
      rd_en     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      idx_q     <= idx_nxt;
      acc_q     <= acc_nxt;
      addr_q    <= addr_nxt;
      size_q    <= size_nxt;
      cmd_q     <= cmd_nxt;
      num_q     <= num_nxt;
      hcnt_q    <= hcnt_nxt;
      rd_pend_q <= rd_pend_nxt;
      byp_q     <= byp_nxt;
      data_q    <= data_nxt;
      rd_addr   <= rd_addr_nxt;
      rd_en     <= rd_en_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state_q;
    idx_nxt       = idx_q;
    acc_nxt       = acc_q;
    addr_nxt      = addr_q;
    size_nxt      = size_q;
    cmd_nxt       = cmd_q;
    num_nxt       = num_q;
    hcnt_nxt      = hcnt_q;
    rd_pend_nxt   = 1'b0;
    byp_nxt       = 1'b0;
    data_nxt      = data_q;
    rd_addr_nxt   = rd_addr;
    rd_en_nxt     = 1'b0;
    out_valid_nxt = out_valid;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;

    unique case (state_q)
      IDLE: begin
        out_valid_nxt = 1'b0;
        if (start) begin
          if (32'(hdr_size) > MAX_SIZE) begin
            err_nxt = 1'b1;
          end else begin
            addr_nxt = hdr_addr;
            size_nxt = hdr_size;
            cmd_nxt  = cmd_decode(hdr_cmd);
            num_nxt  = hdr_num;
            acc_nxt  = '0;
            idx_nxt  = '0;
            hcnt_nxt = '0;
            if (hdr_size == 16'd0) begin
              state_nxt     = HDR;
              out_valid_nxt = 1'b1;
              data_nxt      = {hdr_addr, hdr_size[15:8]};
            end else begin
              state_nxt   = SUM;
              rd_en_nxt   = 1'b1;
              rd_addr_nxt = '0;
              idx_nxt     = IW'(1);
            end
          end
        end
      end

      // Stream reads back to back and add each word the cycle it returns.
      SUM: begin
        rd_pend_nxt = rd_en;
        if (32'(idx_q) < 32'(size_q)) begin
          rd_en_nxt   = 1'b1;
          rd_addr_nxt = BUF_AW'(idx_q);
          idx_nxt     = idx_q + IW'(1);
        end
        if (rd_pend_q) begin
          acc_nxt = acc_q + rd_data;
        end
        if (rd_pend_q && !rd_en) begin
          state_nxt     = HDR;
          idx_nxt       = '0;
          hcnt_nxt      = '0;
          out_valid_nxt = 1'b1;
          data_nxt      = {addr_q, size_q[15:8]};
        end
      end

      HDR: begin
        if (out_valid && out_ready) begin
          if (hcnt_q == 2'd3) begin
            out_valid_nxt = 1'b0;
            if (size_q == 16'd0) begin
              state_nxt = FIN;
              done_nxt  = 1'b1;
            end else begin
              state_nxt   = DATA;
              rd_en_nxt   = 1'b1;
              rd_addr_nxt = BUF_AW'(idx_q);
            end
          end else begin
            hcnt_nxt = hcnt_q + 2'd1;
            case (hcnt_q)
              2'd0:    data_nxt = {size_q[7:0], cmd_q};
              2'd1:    data_nxt = acc_q;
              default: data_nxt = num_q;
            endcase
          end
        end
      end

      DATA: begin
        if (rd_en) begin
          out_valid_nxt = 1'b1;
          byp_nxt       = 1'b1;
          idx_nxt       = idx_q + IW'(1);
        end else if (out_valid) begin
          if (byp_q) begin
            data_nxt = rd_data;
          end
          if (out_ready) begin
            out_valid_nxt = 1'b0;
            if (32'(idx_q) == 32'(size_q)) begin
              state_nxt = FIN;
              done_nxt  = 1'b1;
            end else begin
              rd_en_nxt   = 1'b1;
              rd_addr_nxt = BUF_AW'(idx_q);
            end
          end
        end
      end

      FIN: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt == SUM) || (state_nxt == HDR) || (state_nxt == DATA);
  end

endmodule

// File: tb/tb_service_reply_tx.sv
// tb_service_reply_tx: directed, table-driven bench for service_reply_tx.
module tb_service_reply_tx;

  localparam int unsigned BUF_AW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        hdr_addr;
  logic [15:0]       hdr_size;
  logic [7:0]        hdr_cmd;
  logic [15:0]       hdr_num;
  logic [BUF_AW-1:0] rd_addr;
  logic              rd_en;
  logic [15:0]       rd_data;
  logic [15:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:255];

  always #5 clk = ~clk;

  service_reply_tx #(.BUF_AW(BUF_AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .hdr_addr(hdr_addr), .hdr_size(hdr_size), .hdr_cmd(hdr_cmd), .hdr_num(hdr_num),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  // Reply buffer: data one cycle after rd_en, garbage otherwise.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 16'hDEAD;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] size;
    logic [7:0]  cmd;
    logic [15:0] num;
    logic [63:0] pl;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
    bit          rnd;
    bit          poke;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pay(input vec_t v, input int i);
    if (i < 4) return v.pl[16*i +: 16];
    return 16'(i);
  endfunction

  function automatic logic [15:0] word(input vec_t v, input int k);
    case (k)
      0: return v.w0;
      1: return v.w1;
      2: return v.w2;
      3: return v.num;
      default: return pay(v, k - 4);
    endcase
  endfunction

  // Transfer cycle (relative to the start edge) with out_ready held high.
  function automatic int exp_cycle(input vec_t v, input int k);
    int w0c;
    w0c = (v.size == 16'd0) ? 1 : int'(v.size) + 2;
    if (k < 4) return w0c + k;
    return w0c + 2 * k - 3;
  endfunction

  task automatic run_pkt(input vec_t v, input string tag);
    int nw, ndone, done_c, last_x, stall_bad, timing_bad;
    bit rd_seen, err_seen, busy_done_bad;
    logic pv, pr;
    logic [15:0] pd;
    nw = 0; ndone = 0; done_c = 0; last_x = -10; stall_bad = 0; timing_bad = 0;
    rd_seen = 0; err_seen = 0; busy_done_bad = 0; pv = 0; pr = 0; pd = '0;
    for (int i = 0; i < int'(v.size); i++) mem[i] = pay(v, i);
    @(negedge clk);
    start = 1'b1; hdr_addr = v.addr; hdr_size = v.size; hdr_cmd = v.cmd; hdr_num = v.num;
    out_ready = 1'b1;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      start = v.poke && (c == 3 || c == 7);
      hdr_addr = 8'hEE; hdr_size = 16'd1; hdr_cmd = 8'hA0; hdr_num = 16'hFFFF;
      if (rd_en) rd_seen = 1;
      if (err) err_seen = 1;
      if (pv && !pr && !(out_valid === 1'b1 && out_data === pd)) stall_bad++;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          done_c = c;
          if (busy !== 1'b0) busy_done_bad = 1;
        end
      end
      out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        check($sformatf("%s word%0d", tag, nw), 32'(out_data), 32'(word(v, nw)));
        if (!v.rnd && c != exp_cycle(v, nw)) timing_bad++;
        last_x = c;
        nw++;
      end
      pv = out_valid; pr = out_ready; pd = out_data;
      if (ndone > 0 && c >= done_c + 3) break;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check({tag, " word count"}, 32'(nw), 32'(int'(v.size) + 4));
    check({tag, " done count"}, 32'(ndone), 32'd1);
    check({tag, " done latency"}, 32'(done_c), 32'(last_x + 1));
    check({tag, " busy at done"}, 32'(busy_done_bad), 32'd0);
    check({tag, " stall stability"}, 32'(stall_bad), 32'd0);
    check({tag, " no err"}, 32'(err_seen), 32'd0);
    if (!v.rnd) check({tag, " cadence"}, 32'(timing_bad), 32'd0);
    if (v.size == 16'd0) check({tag, " no rd_en"}, 32'(rd_seen), 32'd0);
  endtask

  initial begin
    int nw, bad;
    bit got;

    vecs[0] = '{addr: 8'h12, size: 16'd3, cmd: 8'hB2, num: 16'h0005,
                pl: 64'h0000_3333_2222_1111, w0: 16'h1200, w1: 16'h03B2, w2: 16'h6666,
                rnd: 1'b0, poke: 1'b0};
    vecs[1] = '{addr: 8'h34, size: 16'd2, cmd: 8'hA2, num: 16'h0007,
                pl: 64'h0000_0000_0002_FFFF, w0: 16'h3400, w1: 16'h02A2, w2: 16'h0001,
                rnd: 1'b0, poke: 1'b1};
    vecs[2] = '{addr: 8'h01, size: 16'd0, cmd: 8'hA0, num: 16'h0100,
                pl: 64'h0, w0: 16'h0100, w1: 16'h00A0, w2: 16'h0000,
                rnd: 1'b0, poke: 1'b0};
    vecs[3] = '{addr: 8'h56, size: 16'd1, cmd: 8'h5A, num: 16'h1234,
                pl: 64'h0000_0000_0000_ABCD, w0: 16'h5600, w1: 16'h01FF, w2: 16'hABCD,
                rnd: 1'b1, poke: 1'b0};
    vecs[4] = '{addr: 8'h9A, size: 16'd4, cmd: 8'hB0, num: 16'hBEEF,
                pl: 64'hFFFE_8000_8000_0001, w0: 16'h9A00, w1: 16'h04B0, w2: 16'hFFFF,
                rnd: 1'b1, poke: 1'b0};
    vecs[5] = '{addr: 8'h77, size: 16'd256, cmd: 8'hA2, num: 16'h0042,
                pl: 64'h0003_0002_0001_0000, w0: 16'h7701, w1: 16'h00A2, w2: 16'h7F80,
                rnd: 1'b0, poke: 1'b0};

    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    hdr_addr = '0; hdr_size = '0; hdr_cmd = '0; hdr_num = '0;
    repeat (3) @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset rd_en", 32'(rd_en), 32'd0);
    check("reset rd_addr", 32'(rd_addr), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < 6; i++) run_pkt(vecs[i], $sformatf("vec%0d", i));

    // Oversize request is rejected with a one-cycle err and no activity.
    @(negedge clk);
    start = 1'b1; hdr_addr = 8'h11; hdr_size = 16'd257; hdr_cmd = 8'hA0; hdr_num = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    check("oversize err", 32'(err), 32'd1);
    check("oversize busy", 32'(busy), 32'd0);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (err || busy || out_valid || rd_en || done) bad++;
    end
    check("oversize quiet", 32'(bad), 32'd0);

    // Reset while payload word 1 of 3 is stalled.
    mem[0] = 16'hA1A1; mem[1] = 16'hB2B2; mem[2] = 16'hC3C3;
    @(negedge clk);
    start = 1'b1; hdr_addr = 8'h21; hdr_size = 16'd3; hdr_cmd = 8'hB0; hdr_num = 16'h0009;
    out_ready = 1'b1;
    nw = 0; got = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && nw == 5) begin
        got = 1;
        break;
      end
      if (out_valid) nw++;
    end
    out_ready = 1'b0;
    check("rstmid reached word1", 32'(got), 32'd1);
    check("rstmid word1", 32'(out_data), 32'hB2B2);
    @(negedge clk);
    check("rstmid stalled valid", 32'(out_valid), 32'd1);
    check("rstmid stalled data", 32'(out_data), 32'hB2B2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid out_valid", 32'(out_valid), 32'd0);
    check("rstmid busy", 32'(busy), 32'd0);
    check("rstmid done", 32'(done), 32'd0);
    check("rstmid rd_en", 32'(rd_en), 32'd0);
    check("rstmid out_data", 32'(out_data), 32'd0);
    out_ready = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || out_valid || busy) bad++;
    end
    check("rstmid quiet", 32'(bad), 32'd0);
    run_pkt(vecs[0], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
